// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types, parity-mode constants and sizing helper for uart_rx_framed
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_framed_sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : single-bit two-flop synchroniser with configurable reset value
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// uart_rx_framed : parametrised UART receiver with valid/ack holding register
// Revision       : 1.0
// ============================================================================
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  input  logic                 i_RX_Ack,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_RX_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int IDX_W = clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  logic rx_s;

  state_e                 state_q,      state_d;
  logic [CNT_W-1:0]       clk_cnt_q,    clk_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q,    bit_idx_d;
  logic                   stop_idx_q,   stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q,      shift_d;
  logic                   par_bad_q,    par_bad_d;
  logic                   stop_bad_q,   stop_bad_d;
  logic                   rx_prev_q,    rx_prev_d;
  logic [DATA_BITS-1:0]   rx_byte_q,    rx_byte_d;
  logic                   rx_valid_q,   rx_valid_d;
  logic                   rx_dv_q,      rx_dv_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q,  frame_err_d;
  logic                   overrun_q,    overrun_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_D    (i_RX_Serial),
    .o_Q    (rx_s)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      rx_prev_q    <= 1'b1;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_dv_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      rx_prev_q    <= rx_prev_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_dv_q      <= rx_dv_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    rx_prev_d    = rx_s;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q & ~i_RX_Ack;
    rx_dv_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    case (state_q)
      // Edge-qualified so a held-low (break) line cannot retrigger a frame.
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            bit_idx_d  = '0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = ST_STOP;
          if (PARITY == PARITY_ODD) begin
            par_bad_d = ~(^shift_q ^ rx_s);
          end else if (PARITY == PARITY_EVEN) begin
            par_bad_d = ^shift_q ^ rx_s;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      // Leaving at the mid-sample lets a back-to-back start edge be seen.
      ST_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            stop_bad_d = 1'b1;
          end
          if (stop_idx_q == LAST_STOP) begin
            state_d = ST_DONE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        rx_byte_d    = shift_q;
        parity_err_d = par_bad_q;
        frame_err_d  = stop_bad_q;
        rx_dv_d      = 1'b1;
        rx_valid_d   = 1'b1;
        overrun_d    = overrun_q | (rx_valid_q & ~i_RX_Ack);
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_RX_DV      = rx_dv_q;
  assign o_RX_Byte    = rx_byte_q;
  assign o_RX_Valid   = rx_valid_q;
  assign o_Parity_Err = parity_err_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Overrun    = overrun_q;
  assign o_Busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_rx_framed : four receiver configurations driven by directed and random frames
// Revision          : 1.0
// ============================================================================
module tb_uart_rx_framed;

  localparam int CPB = 8;
  localparam int NI  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line  [NI];
  logic       ack   [NI];
  logic       dv    [NI];
  logic       valid [NI];
  logic       perr  [NI];
  logic       ferr  [NI];
  logic       ovr   [NI];
  logic       busy  [NI];
  logic [7:0] rbyte [NI];

  always #5 clk = ~clk;

  // Instance map: 0 = 8N1, 1 = 8E1, 2 = 8N2, 3 = 5O2
  function automatic int dw_of(input int g);
    return (g == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int g);
    return (g == 1) ? 2 : ((g == 3) ? 1 : 0);
  endfunction
  function automatic int stop_of(input int g);
    return (g >= 2) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = (g == 3) ? 5 : 8;
    localparam int PM = (g == 1) ? 2 : ((g == 3) ? 1 : 0);
    localparam int SB = (g >= 2) ? 2 : 1;
    logic [DW-1:0] b;
    uart_rx_framed #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DW),
      .PARITY      (PM),
      .STOP_BITS   (SB)
    ) u_dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_RX_Serial (line[g]),
      .i_RX_Ack    (ack[g]),
      .o_RX_DV     (dv[g]),
      .o_RX_Byte   (b),
      .o_RX_Valid  (valid[g]),
      .o_Parity_Err(perr[g]),
      .o_Frame_Err (ferr[g]),
      .o_Overrun   (ovr[g]),
      .o_Busy      (busy[g])
    );
    assign rbyte[g] = 8'(b);
  end

  typedef struct {
    int         g;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         dv_cyc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic       m_valid [NI];
  logic       m_ovr   [NI];
  logic       m_pe    [NI];
  logic       m_fe    [NI];
  logic [7:0] m_byte  [NI];
  int         dv_count [NI];

  bit   ack_rand = 1'b0;
  logic ack_man [NI];
  int   ack_at  [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model and per-cycle compare, sampled just after each rising edge.
  initial begin : p_compare
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      m_valid[g] = 0; m_ovr[g] = 0; m_pe[g] = 0; m_fe[g] = 0; m_byte[g] = 0; dv_count[g] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int g = 0; g < NI; g++) begin
        if (rst) begin
          m_valid[g] = 0; m_ovr[g] = 0; m_pe[g] = 0; m_fe[g] = 0; m_byte[g] = 0;
        end else if (dv[g]) begin
          check($sformatf("dv_expected[%0d]", g), 32'(expq.size() > 0 && expq[0].g == g), 32'd1);
          if (expq.size() > 0 && expq[0].g == g) begin
            e = expq.pop_front();
            check($sformatf("dv_cycle[%0d]", g), cyc, e.dv_cyc);
            m_ovr[g]   = m_ovr[g] | (m_valid[g] & ~ack[g]);
            m_valid[g] = 1'b1;
            m_byte[g]  = e.data;
            m_pe[g]    = e.pe;
            m_fe[g]    = e.fe;
            dv_count[g]++;
          end
        end else begin
          if (expq.size() > 0 && expq[0].g == g && cyc >= expq[0].dv_cyc) begin
            check($sformatf("dv_missing[%0d]", g), 32'(dv[g]), 32'd1);
            void'(expq.pop_front());
          end
          if (ack[g]) m_valid[g] = 1'b0;
        end
        check($sformatf("hold[%0d]{byte,pe,fe,valid,ovr}", g),
              {19'd0, rbyte[g], perr[g], ferr[g], valid[g], ovr[g]},
              {19'd0, m_byte[g], m_pe[g], m_fe[g], m_valid[g], m_ovr[g]});
      end
      if (rst) expq.delete();
    end
  end

  initial begin : p_ack
    for (int g = 0; g < NI; g++) begin
      ack[g] = 1'b0; ack_man[g] = 1'b0; ack_at[g] = -1;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int g = 0; g < NI; g++)
        ack[g] = ack_man[g] | (ack_at[g] == cyc + 1) | (ack_rand && $urandom_range(0, 3) == 0);
    end
  end

  initial begin : p_watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input int g, input logic b);
    line[g] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int g, input int n);
    line[g] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the line is left at the last stop-bit level.
  task automatic send(input int g, input logic [7:0] data, input bit bad_par,
                      input logic [1:0] stops, input bit ack_done);
    int         dw, p, s, nbits;
    logic [7:0] d;
    logic       x, pb;
    exp_t       e;
    dw = dw_of(g); p = par_of(g); s = stop_of(g);
    d  = data & (8'hFF >> (8 - dw));
    x  = ^d;
    pb = (p == 1) ? ~x : x;
    if (bad_par) pb = ~pb;
    nbits    = 1 + dw + ((p != 0) ? 1 : 0) + s;
    e.g      = g;
    e.data   = d;
    e.pe     = (p == 0) ? 1'b0 : ((p == 1) ? ~(x ^ pb) : (x ^ pb));
    e.fe     = !stops[0] || (s == 2 && !stops[1]);
    e.dv_cyc = cyc + 1 + 3 + CPB / 2 + CPB * (nbits - 1);
    if (ack_done) ack_at[g] = e.dv_cyc;
    expq.push_back(e);
    drive(g, 1'b0);
    for (int i = 0; i < dw; i++) drive(g, d[i]);
    if (p != 0) drive(g, pb);
    drive(g, stops[0]);
    if (s == 2) drive(g, stops[1]);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : p_main
    int         n0;
    bit         seen_busy, busy_ok, fe_c;
    logic [1:0] st;
    for (int g = 0; g < NI; g++) line[g] = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++)
      check($sformatf("reset_state[%0d]", g),
            {18'd0, dv[g], valid[g], busy[g], perr[g], ferr[g], ovr[g], rbyte[g]}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0xA5, then acknowledge
    send(0, 8'hA5, 0, 2'b11, 0);
    idle(0, 1);
    check("t1_dv_count", dv_count[0], 1);
    check("t1_byte", rbyte[0], 8'hA5);
    check("t1_valid", valid[0], 1'b1);
    check("t1_errs", {perr[0], ferr[0]}, 2'b00);
    ack_man[0] = 1'b1;
    @(negedge clk);
    ack_man[0] = 1'b0;
    @(negedge clk);
    check("t1_valid_after_ack", valid[0], 1'b0);

    // Even parity, 0x07 with wrong then right parity bit
    send(1, 8'h07, 1, 2'b11, 0);
    idle(1, CPB);
    check("t2_bad_parity", perr[1], 1'b1);
    check("t2_byte", rbyte[1], 8'h07);
    send(1, 8'h07, 0, 2'b11, 0);
    idle(1, CPB);
    check("t2_good_parity", perr[1], 1'b0);

    // Start glitch of two clocks
    n0 = dv_count[0];
    line[0] = 1'b0;
    repeat (2) @(negedge clk);
    line[0] = 1'b1;
    seen_busy = 0; busy_ok = 0;
    for (int i = 0; i < CPB / 2 + 1; i++) begin
      @(posedge clk);
      #2;
      if (busy[0]) seen_busy = 1;
      else if (seen_busy) begin busy_ok = 1; break; end
    end
    @(negedge clk);
    check("t3_glitch_started", seen_busy, 1'b1);
    check("t3_busy_returned", busy_ok, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("t3_no_dv", dv_count[0], n0);

    // Back-to-back without ack -> overrun, sticky until reset
    send(0, 8'h3C, 0, 2'b11, 0);
    send(0, 8'hC3, 0, 2'b11, 0);
    idle(0, 1);
    check("t4_byte", rbyte[0], 8'hC3);
    check("t4_overrun", ovr[0], 1'b1);
    repeat (40) @(negedge clk);
    check("t4_overrun_sticky", ovr[0], 1'b1);
    reset_pulse();
    check("t4_overrun_reset", ovr[0], 1'b0);
    send(0, 8'h3C, 0, 2'b11, 0);
    send(0, 8'hC3, 0, 2'b11, 1);
    idle(0, 1);
    check("t4_ack_in_done_ovr", ovr[0], 1'b0);
    check("t4_ack_in_done_valid", valid[0], 1'b1);
    check("t4_ack_in_done_byte", rbyte[0], 8'hC3);

    // Two stop bits, second one low
    send(2, 8'h55, 0, 2'b01, 0);
    idle(2, 2 * CPB);
    check("t5_frame_err", ferr[2], 1'b1);
    check("t5_byte", rbyte[2], 8'h55);

    // Break: line held low through and after the frame
    n0 = dv_count[0];
    send(0, 8'h00, 0, 2'b00, 0);
    repeat (3 * CPB) @(negedge clk);
    check("brk_dv_once", dv_count[0], n0 + 1);
    check("brk_frame_err", ferr[0], 1'b1);
    check("brk_byte", rbyte[0], 8'h00);
    check("brk_idle_wait", busy[0], 1'b0);
    idle(0, 2 * CPB);

    // 5O2: valid frame, then reset during data bit 3 of 0x1F, then 0x0A
    send(3, 8'h15, 0, 2'b11, 0);
    idle(3, CPB);
    check("t6_pre_byte", rbyte[3], 8'h15);
    n0 = dv_count[3];
    drive(3, 1'b0);
    for (int i = 0; i < 3; i++) drive(3, 1'b1);
    line[3] = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("t6_busy_mid_frame", busy[3], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_reset_outputs",
          {18'd0, dv[3], valid[3], busy[3], perr[3], ferr[3], ovr[3], rbyte[3]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("t6_no_dv", dv_count[3], n0);
    send(3, 8'h0A, 0, 2'b11, 0);
    idle(3, CPB);
    check("t6_byte", rbyte[3], 8'h0A);
    check("t6_errs", {perr[3], ferr[3]}, 2'b00);

    // Randomised frames on every configuration with random acknowledges
    ack_rand = 1'b1;
    for (int g = 0; g < NI; g++) begin
      for (int r = 0; r < 25; r++) begin
        st[0] = ($urandom_range(0, 5) != 0);
        st[1] = ($urandom_range(0, 5) != 0);
        fe_c  = !st[0] || (stop_of(g) == 2 && !st[1]);
        send(g, 8'($urandom), ($urandom_range(0, 4) == 0), st, ($urandom_range(0, 5) == 0));
        if (fe_c || $urandom_range(0, 2) != 0) idle(g, CPB * $urandom_range(1, 3));
      end
      idle(g, 2 * CPB);
    end
    ack_rand = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("pending_frames", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
